// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXIS round-robin packet arbiter.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
package axis_arb_pkg;

    localparam int MAX_SRC = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_t;

    // First requester strictly after `last`, searching upward and wrapping at n_src.
    // Returns `last` unchanged when nobody requests (callers only use it when req != 0).
    function automatic logic [2:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                           input logic [2:0]         last,
                                           input int                 n_src);
        logic [2:0] pick;
        int         idx;
        pick = last;
        // Walk from farthest to nearest so the nearest requester wins.
        for (int k = MAX_SRC; k >= 1; k--) begin
            idx = (int'(last) + k) % n_src;
            if ((k <= n_src) && req[3'(idx)]) begin
                pick = 3'(idx);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry valid/ready register slice with a registered upstream ready.
// Latency: 1 cycle from input accept to o_m_vld; 1 beat/clk when i_m_rdy stays high.
// Backpressure: o_s_rdy drops the cycle after a stall fills the skid entry; o_m_dat holds while stalled.
module axis_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_s_vld,
    output logic         o_s_rdy,
    input  logic [W-1:0] i_s_dat,
    output logic         o_m_vld,
    input  logic         i_m_rdy,
    output logic [W-1:0] o_m_dat,
    output logic         o_busy
);

    logic         r_m_vld;
    logic [W-1:0] r_m_dat;
    logic         r_skid_vld;
    logic [W-1:0] r_skid_dat;
    logic         r_s_rdy;
    logic         w_push;
    logic         w_pop;

    assign w_push  = i_s_vld && r_s_rdy;
    assign w_pop   = r_m_vld && i_m_rdy;
    assign o_s_rdy = r_s_rdy;
    assign o_m_vld = r_m_vld;
    assign o_m_dat = r_m_dat;
    assign o_busy  = r_m_vld || r_skid_vld;

    // Main/skid register update; r_s_rdy always mirrors "skid entry empty".
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_vld    <= 1'b0;
            r_m_dat    <= '0;
            r_skid_vld <= 1'b0;
            r_skid_dat <= '0;
            r_s_rdy    <= 1'b1;
        end else if (r_skid_vld) begin
            // Upstream is held off; drain the skid entry into main when it frees.
            if (w_pop) begin
                r_m_dat    <= r_skid_dat;
                r_skid_vld <= 1'b0;
                r_s_rdy    <= 1'b1;
            end
        end else if (w_push) begin
            if (!r_m_vld || i_m_rdy) begin
                r_m_vld <= 1'b1;
                r_m_dat <= i_s_dat;
            end else begin
                r_skid_vld <= 1'b1;
                r_skid_dat <= i_s_dat;
                r_s_rdy    <= 1'b0;
            end
        end else if (w_pop) begin
            r_m_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Round-robin arbiter sharing one AXIS port among N_SRC streams; grant held per packet or burst.
// Latency: 1 arbitration cycle per grant, then 1 cycle input accept to m_axis_tvalid.
// Backpressure: s_axis_tready of the granted source follows the slice's registered ready.
module axis_rr_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int DWIDTH    = 8,
    parameter int IDW       = 2,
    parameter int USE_TLAST = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [N_SRC*DWIDTH-1:0] s_axis_tdata,
    input  logic [N_SRC-1:0]        s_axis_tvalid,
    input  logic [N_SRC-1:0]        s_axis_tlast,
    output logic [N_SRC-1:0]        s_axis_tready,
    output logic [DWIDTH-1:0]       m_axis_tdata,
    output logic [IDW-1:0]          m_axis_tid,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic [31:0]             pkt_count
);

    localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef struct packed {
        logic [IDW-1:0]    tid;
        logic              tlast;
        logic [DWIDTH-1:0] tdata;
    } beat_t;

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [GW-1:0]      r_grant;
    logic [GW-1:0]      r_last_grant;
    logic [GW-1:0]      w_pick;
    logic [8:0]         r_beat_cnt;
    logic [31:0]        r_pkt_count;
    logic [MAX_SRC-1:0] w_req;
    logic [DWIDTH-1:0]  w_src_dat [N_SRC];
    logic               w_sel_vld;
    logic               w_sel_last;
    logic               w_slice_rdy;
    logic               w_slice_busy;
    logic               w_slice_vld;
    logic               w_accept;
    logic               w_release;
    logic               w_start;
    beat_t              w_in_beat;
    beat_t              w_out_beat;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign w_src_dat[g] = s_axis_tdata[g*DWIDTH +: DWIDTH];
    end

    // Widen the request vector to the helper's fixed width.
    always_comb begin
        w_req              = '0;
        w_req[N_SRC-1:0]   = s_axis_tvalid;
    end

    assign w_pick     = GW'(rr_pick(w_req, 3'(r_last_grant), N_SRC));
    assign w_sel_vld  = s_axis_tvalid[r_grant];
    assign w_sel_last = s_axis_tlast[r_grant];
    assign w_start    = (r_state == IDLE) && enable && (|s_axis_tvalid);
    assign w_accept   = (r_state == ACTIVE) && w_sel_vld && w_slice_rdy;

    if (USE_TLAST != 0) begin : g_rel_tlast
        assign w_release = w_accept && w_sel_last;
    end else begin : g_rel_burst
        // Burst ends on the MAX_BURST-th beat, or as soon as the source goes quiet after sending.
        assign w_release = (w_accept && ((r_beat_cnt + 9'd1) == 9'(MAX_BURST)))
                        || ((r_state == ACTIVE) && !w_sel_vld && (r_beat_cnt != 9'd0));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: one idle arbitration cycle, then hold until the release condition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start)   w_state_nxt = ACTIVE;
            ACTIVE:  if (w_release) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs: only the granted source sees ready, and only while ACTIVE.
    always_comb begin
        s_axis_tready = '0;
        if (r_state == ACTIVE) begin
            s_axis_tready[r_grant] = w_slice_rdy;
        end
    end

    // Grant bookkeeping; last_grant resets to N_SRC-1 so source 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= '0;
            r_last_grant <= GW'(N_SRC - 1);
            r_beat_cnt   <= '0;
            r_pkt_count  <= '0;
        end else begin
            if (w_start) begin
                r_grant      <= w_pick;
                r_last_grant <= w_pick;
                r_beat_cnt   <= '0;
            end
            if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + 9'd1;
            end
            if (w_release) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    assign w_in_beat.tid   = IDW'(r_grant);
    assign w_in_beat.tlast = (USE_TLAST != 0) ? w_sel_last : 1'b0;
    assign w_in_beat.tdata = w_src_dat[r_grant];

    axis_skid_buffer #(
        .W ($bits(beat_t))
    ) u_slice (
        .clk     (clk),
        .rst     (rst),
        .i_s_vld (w_accept),
        .o_s_rdy (w_slice_rdy),
        .i_s_dat (w_in_beat),
        .o_m_vld (w_slice_vld),
        .i_m_rdy (m_axis_tready),
        .o_m_dat (w_out_beat),
        .o_busy  (w_slice_busy)
    );

    assign m_axis_tvalid = w_slice_vld;
    assign m_axis_tdata  = w_out_beat.tdata;
    assign m_axis_tid    = w_out_beat.tid;
    assign m_axis_tlast  = w_out_beat.tlast;
    assign busy          = (r_state == ACTIVE) || w_slice_busy;
    assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed bench for the AXIS round-robin packet arbiter (packet mode and burst mode instances).
// Latency: n/a.
// Backpressure: sink ready driven from per-test patterns.
module tb_axis_rr_packet_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        en_a, en_b;
    logic [3:0]  tvalid_a, tlast_a, tready_a, tvalid_b, tlast_b, tready_b;
    logic [31:0] tdata_a, tdata_b, pkt_a, pkt_b;
    logic [7:0]  mdata_a, mdata_b;
    logic [1:0]  mtid_a, mtid_b;
    logic        mlast_a, mvld_a, mrdy_a, busy_a;
    logic        mlast_b, mvld_b, mrdy_b, busy_b;

    axis_rr_packet_arbiter #(.N_SRC(4), .DWIDTH(8), .IDW(2), .USE_TLAST(1), .MAX_BURST(16)) dut (
        .clk(clk), .rst(rst), .enable(en_a),
        .s_axis_tdata(tdata_a), .s_axis_tvalid(tvalid_a), .s_axis_tlast(tlast_a), .s_axis_tready(tready_a),
        .m_axis_tdata(mdata_a), .m_axis_tid(mtid_a), .m_axis_tlast(mlast_a), .m_axis_tvalid(mvld_a),
        .m_axis_tready(mrdy_a), .busy(busy_a), .pkt_count(pkt_a));

    axis_rr_packet_arbiter #(.N_SRC(4), .DWIDTH(8), .IDW(2), .USE_TLAST(0), .MAX_BURST(4)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b),
        .s_axis_tdata(tdata_b), .s_axis_tvalid(tvalid_b), .s_axis_tlast(tlast_b), .s_axis_tready(tready_b),
        .m_axis_tdata(mdata_b), .m_axis_tid(mtid_b), .m_axis_tlast(mlast_b), .m_axis_tvalid(mvld_b),
        .m_axis_tready(mrdy_b), .busy(busy_b), .pkt_count(pkt_b));

    int          checks = 0;
    int          failures = 0;
    int          sel;
    logic [8:0]  src_mem [4][16];
    int          src_len [4];
    int          src_ptr [4];
    logic [3:0]  pend;
    logic [10:0] out_beat [64];
    int          out_cyc [64];
    int          out_n;
    int          acc_src [64];
    int          acc_cyc [64];
    int          acc_n;
    logic        rdy_pat [64];
    int          rdy_len;
    logic        tr_srdy [64];
    int          cyc;
    int          stall_changes;
    logic        prev_stall;
    logic [10:0] prev_beat;

    task automatic clear_inputs();
        tvalid_a = '0; tlast_a = '0; tdata_a = '0; mrdy_a = 1'b1; en_a = 1'b1;
        tvalid_b = '0; tlast_b = '0; tdata_b = '0; mrdy_b = 1'b1; en_b = 1'b1;
    endtask

    task automatic clear_state();
        for (int i = 0; i < 4; i++) begin
            src_len[i] = 0;
            src_ptr[i] = 0;
        end
        pend = '0; out_n = 0; acc_n = 0; rdy_len = 0; cyc = 0;
        stall_changes = 0; prev_stall = 1'b0; prev_beat = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        clear_state();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Source s gets n beats base, base+1, ...; tlast every plen beats (plen=0: never).
    task automatic load_src(input int s, input int n, input logic [7:0] base, input int plen);
        for (int k = 0; k < n; k++) begin
            src_mem[s][k] = {(plen != 0) && (((k + 1) % plen) == 0), base + 8'(k)};
        end
        src_len[s] = n;
    endtask

    // One clock of source/sink modelling against the selected instance.
    task automatic step();
        logic [3:0]  sv, sl, trdy;
        logic [31:0] sd;
        logic        mv, mr;
        logic [10:0] mb;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (pend[i]) src_ptr[i]++;
        trdy = (sel == 1) ? tready_b : tready_a;
        mv   = (sel == 1) ? mvld_b : mvld_a;
        mb   = (sel == 1) ? {mtid_b, mlast_b, mdata_b} : {mtid_a, mlast_a, mdata_a};
        mr   = (cyc < rdy_len) ? rdy_pat[cyc] : 1'b1;
        if (prev_stall && mv && (mb != prev_beat)) stall_changes++;
        prev_stall = mv && !mr;
        prev_beat  = mb;
        if (mv && mr && (out_n < 64)) begin
            out_beat[out_n] = mb;
            out_cyc[out_n]  = cyc;
            out_n++;
        end
        sd = '0;
        for (int i = 0; i < 4; i++) begin
            sv[i] = src_ptr[i] < src_len[i];
            {sl[i], sd[i*8 +: 8]} = sv[i] ? src_mem[i][src_ptr[i]] : 9'h0;
        end
        pend = sv & trdy;
        for (int i = 0; i < 4; i++) begin
            if (pend[i] && (acc_n < 64)) begin
                acc_src[acc_n] = i;
                acc_cyc[acc_n] = cyc;
                acc_n++;
            end
        end
        if (sel == 1) begin
            tvalid_b = sv; tlast_b = sl; tdata_b = sd; mrdy_b = mr;
        end else begin
            tvalid_a = sv; tlast_a = sl; tdata_a = sd; mrdy_a = mr;
        end
        if (cyc < 64) tr_srdy[cyc] = |trdy;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 14;
        if (mvld_a !== 1'b0)   begin failures++; $display("FAIL rst_mvld_a got=%b exp=0", mvld_a); end
        if (tready_a !== 4'h0) begin failures++; $display("FAIL rst_tready_a got=%h exp=0", tready_a); end
        if (mdata_a !== 8'h00) begin failures++; $display("FAIL rst_mdata_a got=%h exp=0", mdata_a); end
        if (mtid_a !== 2'd0)   begin failures++; $display("FAIL rst_mtid_a got=%h exp=0", mtid_a); end
        if (mlast_a !== 1'b0)  begin failures++; $display("FAIL rst_mlast_a got=%b exp=0", mlast_a); end
        if (busy_a !== 1'b0)   begin failures++; $display("FAIL rst_busy_a got=%b exp=0", busy_a); end
        if (pkt_a !== 32'd0)   begin failures++; $display("FAIL rst_pkt_a got=%0d exp=0", pkt_a); end
        if (mvld_b !== 1'b0)   begin failures++; $display("FAIL rst_mvld_b got=%b exp=0", mvld_b); end
        if (tready_b !== 4'h0) begin failures++; $display("FAIL rst_tready_b got=%h exp=0", tready_b); end
        if (mdata_b !== 8'h00) begin failures++; $display("FAIL rst_mdata_b got=%h exp=0", mdata_b); end
        if (mtid_b !== 2'd0)   begin failures++; $display("FAIL rst_mtid_b got=%h exp=0", mtid_b); end
        if (mlast_b !== 1'b0)  begin failures++; $display("FAIL rst_mlast_b got=%b exp=0", mlast_b); end
        if (busy_b !== 1'b0)   begin failures++; $display("FAIL rst_busy_b got=%b exp=0", busy_b); end
        if (pkt_b !== 32'd0)   begin failures++; $display("FAIL rst_pkt_b got=%0d exp=0", pkt_b); end
    endtask

    task automatic test_single_packet();
        logic [10:0] exp [3];
        exp = '{11'h0A0, 11'h0A1, 11'h1A2};
        do_reset();
        sel = 0;
        load_src(0, 3, 8'hA0, 3);
        run(12);
        checks++;
        if (out_n !== 3) begin failures++; $display("FAIL t1_count got=%0d exp=3", out_n); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_beat[k] !== exp[k]) begin failures++; $display("FAIL t1_beat[%0d] got=%h exp=%h", k, out_beat[k], exp[k]); end
        end
        checks += 3;
        if (out_cyc[0] !== 2) begin failures++; $display("FAIL t1_latency got=%0d exp=2", out_cyc[0]); end
        if (pkt_a !== 32'd1)  begin failures++; $display("FAIL t1_pkt got=%0d exp=1", pkt_a); end
        if (busy_a !== 1'b0)  begin failures++; $display("FAIL t1_busy got=%b exp=0", busy_a); end
    endtask

    task automatic test_round_robin();
        logic [10:0] exp [10];
        exp = '{11'h080, 11'h181, 11'h290, 11'h391, 11'h4A0, 11'h5A1, 11'h6B0, 11'h7B1, 11'h082, 11'h183};
        do_reset();
        sel = 0;
        load_src(0, 4, 8'h80, 2);
        load_src(1, 2, 8'h90, 2);
        load_src(2, 2, 8'hA0, 2);
        load_src(3, 2, 8'hB0, 2);
        run(20);
        checks += 2;
        if (out_n !== 10)    begin failures++; $display("FAIL t2_count got=%0d exp=10", out_n); end
        if (pkt_a !== 32'd5) begin failures++; $display("FAIL t2_pkt got=%0d exp=5", pkt_a); end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (out_beat[k] !== exp[k]) begin failures++; $display("FAIL t2_beat[%0d] got=%h exp=%h", k, out_beat[k], exp[k]); end
        end
        for (int p = 1; p < 5; p++) begin
            checks++;
            if (acc_cyc[2*p] - acc_cyc[2*p-1] !== 2) begin
                failures++;
                $display("FAIL t2_gap[%0d] got=%0d exp=2", p, acc_cyc[2*p] - acc_cyc[2*p-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] exp [4];
        exp = '{11'h0C0, 11'h0C1, 11'h0C2, 11'h1C3};
        do_reset();
        sel = 0;
        load_src(0, 4, 8'hC0, 4);
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b1; rdy_pat[2] = 1'b1;
        rdy_pat[3] = 1'b0; rdy_pat[4] = 1'b0; rdy_pat[5] = 1'b1;
        rdy_len = 6;
        run(14);
        checks++;
        if (out_n !== 4) begin failures++; $display("FAIL t3_count got=%0d exp=4", out_n); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_beat[k] !== exp[k]) begin failures++; $display("FAIL t3_beat[%0d] got=%h exp=%h", k, out_beat[k], exp[k]); end
        end
        checks += 4;
        if (stall_changes !== 0) begin failures++; $display("FAIL t3_stable got=%0d changes exp=0", stall_changes); end
        if (tr_srdy[3] !== 1'b1) begin failures++; $display("FAIL t3_srdy_stall0 got=%b exp=1", tr_srdy[3]); end
        if (tr_srdy[4] !== 1'b0) begin failures++; $display("FAIL t3_srdy_stall1 got=%b exp=0", tr_srdy[4]); end
        if (pkt_a !== 32'd1)     begin failures++; $display("FAIL t3_pkt got=%0d exp=1", pkt_a); end
    endtask

    task automatic test_burst_mode();
        logic [10:0] exp [12];
        exp = '{11'h210, 11'h211, 11'h212, 11'h213, 11'h420, 11'h421,
                11'h214, 11'h215, 11'h216, 11'h217, 11'h218, 11'h219};
        do_reset();
        sel = 1;
        load_src(1, 10, 8'h10, 0);
        load_src(2, 2, 8'h20, 0);
        run(40);
        checks += 2;
        if (out_n !== 12)    begin failures++; $display("FAIL t4_count got=%0d exp=12", out_n); end
        if (pkt_b !== 32'd4) begin failures++; $display("FAIL t4_pkt got=%0d exp=4", pkt_b); end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (out_beat[k] !== exp[k]) begin failures++; $display("FAIL t4_beat[%0d] got=%h exp=%h", k, out_beat[k], exp[k]); end
        end
        sel = 0;
    endtask

    task automatic test_enable();
        logic [10:0] exp [5];
        exp = '{11'h0D0, 11'h0D1, 11'h1D2, 11'h2E0, 11'h3E1};
        do_reset();
        sel = 0;
        load_src(0, 3, 8'hD0, 3);
        load_src(1, 2, 8'hE0, 2);
        run(2);
        en_a = 1'b0;
        run(12);
        checks += 3;
        if (out_n !== 3)     begin failures++; $display("FAIL t5_hold_count got=%0d exp=3", out_n); end
        if (pkt_a !== 32'd1) begin failures++; $display("FAIL t5_hold_pkt got=%0d exp=1", pkt_a); end
        if (acc_n !== 3)     begin failures++; $display("FAIL t5_hold_acc got=%0d exp=3", acc_n); end
        en_a = 1'b1;
        run(8);
        checks += 2;
        if (out_n !== 5)     begin failures++; $display("FAIL t5_count got=%0d exp=5", out_n); end
        if (pkt_a !== 32'd2) begin failures++; $display("FAIL t5_pkt got=%0d exp=2", pkt_a); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_beat[k] !== exp[k]) begin failures++; $display("FAIL t5_beat[%0d] got=%h exp=%h", k, out_beat[k], exp[k]); end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        sel = 0;
        load_src(0, 4, 8'h40, 4);
        for (int i = 0; i < 64; i++) rdy_pat[i] = 1'b0;
        rdy_len = 64;
        run(6);
        checks++;
        if (mvld_a !== 1'b1) begin failures++; $display("FAIL t6_stalled got=%b exp=1", mvld_a); end
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        checks += 5;
        if (mvld_a !== 1'b0)   begin failures++; $display("FAIL t6_mvld got=%b exp=0", mvld_a); end
        if (tready_a !== 4'h0) begin failures++; $display("FAIL t6_tready got=%h exp=0", tready_a); end
        if (pkt_a !== 32'd0)   begin failures++; $display("FAIL t6_pkt got=%0d exp=0", pkt_a); end
        if (busy_a !== 1'b0)   begin failures++; $display("FAIL t6_busy got=%b exp=0", busy_a); end
        if (mdata_a !== 8'h00) begin failures++; $display("FAIL t6_mdata got=%h exp=0", mdata_a); end
        rst = 1'b0;
        clear_state();
        load_src(0, 1, 8'h55, 1);
        load_src(3, 1, 8'h66, 1);
        run(10);
        checks += 3;
        if (out_n !== 2)             begin failures++; $display("FAIL t6_count got=%0d exp=2", out_n); end
        if (out_beat[0] !== 11'h155) begin failures++; $display("FAIL t6_first got=%h exp=155", out_beat[0]); end
        if (out_beat[1] !== 11'h766) begin failures++; $display("FAIL t6_second got=%h exp=766", out_beat[1]); end
    endtask

    initial begin
        sel = 0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_burst_mode();
        test_enable();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
